// File: rtl/l2_fill_responder.sv
// l2_fill_responder
//
// Second-level fill responder for L1 data-cache misses. Miss addresses are
// queued in a small in-order FIFO. Each one is looked up in a direct-mapped
// line store. A hit returns the stored line. A miss fetches the line over a
// req/ack memory port, allocates it, and then returns it. Every response is a
// single-cycle fill_valid pulse.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   miss_valid/ready    miss request handshake (miss_addr carried alongside)
//   fill_valid          one-cycle response pulse with fill_addr / fill_data
//   mem_req/mem_addr    memory read request, held until mem_ack
//   mem_ack/mem_data    memory read response, sampled only in MEM_WAIT
//   busy                FSM not idle or requests still queued
//   dbg_state_o         current FSM state (IDLE=0, LOOKUP=1, MEM_WAIT=2, RESP=3)
//
// Handshake semantics: a miss is transferred on every rising edge where
// miss_valid && miss_ready. miss_ready depends only on FIFO occupancy, so it
// is not lowered combinationally by miss_valid. mem_req is raised and held,
// together with a stable mem_addr, until the edge that samples mem_ack=1.

module l2_fill_responder #(
  parameter int LINES      = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        miss_valid,
  input  logic [63:0] miss_addr,
  output logic        miss_ready,
  output logic        fill_valid,
  output logic [63:0] fill_addr,
  output logic [63:0] fill_data,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_data,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  localparam int IDX = $clog2(LINES);
  localparam int TW  = 64 - IDX - 3;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM_WAIT, RESP} state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------- FIFO
  logic [63:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // A full FIFO refuses a push even when IDLE pops in the same cycle.
  assign push       = miss_valid && !fifo_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= miss_addr;
  end

  // ---------------------------------------------------------- line store
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [63:0]      data_mem [LINES];

  logic [63:0]  cur_addr_q;
  logic [IDX-1:0] cur_idx;
  logic [TW-1:0]  cur_tag;
  logic           hit;

  assign cur_idx = cur_addr_q[IDX+2:3];
  assign cur_tag = cur_addr_q[63:IDX+3];
  assign hit     = valid_q[cur_idx] && (tag_mem[cur_idx] == cur_tag);

  // ----------------------------------------------------------------- FSM
  logic load_hit, load_mem, start_mem;

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load_hit  = 1'b0;
    load_mem  = 1'b0;
    start_mem = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          load_hit = 1'b1;
          state_d  = RESP;
        end else begin
          start_mem = 1'b1;
          state_d   = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          load_mem = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [63:0] fill_addr_q, fill_data_q, mem_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
      mem_addr_q  <= '0;
      valid_q     <= '0;
    end else begin
      state_q <= state_d;
      if (pop) cur_addr_q <= fifo_mem[rd_ptr_q];
      // fill_addr is captured on entry to RESP so it equals cur_addr for the
      // whole pulse and holds afterwards.
      if (load_hit) begin
        fill_data_q <= data_mem[cur_idx];
        fill_addr_q <= cur_addr_q;
      end
      if (start_mem) mem_addr_q <= cur_addr_q;
      if (load_mem) begin
        fill_data_q      <= mem_data;
        fill_addr_q      <= cur_addr_q;
        valid_q[cur_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate every use.
  // Allocation simply overwrites the old occupant since the L2 is clean.
  always_ff @(posedge clk) begin
    if (load_mem) begin
      tag_mem[cur_idx]  <= cur_tag;
      data_mem[cur_idx] <= mem_data;
    end
  end

  assign miss_ready  = !fifo_full;
  assign fill_valid  = (state_q == RESP);
  assign fill_addr   = fill_addr_q;
  assign fill_data   = fill_data_q;
  // Decoded from state so it falls as soon as reset is asserted.
  assign mem_req     = (state_q == MEM_WAIT);
  assign mem_addr    = mem_addr_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;
  assign dbg_state_o = state_q;

endmodule

// File: doc/l2_fill_responder.md
# l2_fill_responder

Second-level fill responder serving data-cache misses. It accepts miss addresses from the L1 data cache, buffers up to FIFO_DEPTH outstanding requests, and looks each one up in a direct-mapped L2 line store. On a hit it returns the data. On a miss it fetches the line over a req/ack memory port, allocates it, then returns it. Every response is a single-cycle `fill_valid` pulse carrying `fill_addr` and `fill_data`, which drives the L1 fill inputs (`cache_in_start`, `cache_address`, `cache_in`).

## Interface
- `LINES`, 256: L2 line count; power of two; `IDX = log2(LINES)`.
- `FIFO_DEPTH`, 4: miss request queue depth; power of two, ≥ 2.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `miss_valid` in 1: L1 presents a miss request.
- `miss_addr` in 64: byte address of the missed 64-bit word.
- `miss_ready` out 1: queue can accept; equals `!fifo_full`.
- `fill_valid` out 1: one-cycle response pulse.
- `fill_addr` out 64: `miss_addr` of the request being answered, bit-exact.
- `fill_data` out 64: response data.
- `mem_req` out 1: memory read request; held until acknowledged.
- `mem_addr` out 64: memory read address; equals `miss_addr` of the current request.
- `mem_ack` in 1: memory returns `mem_data` this cycle.
- `mem_data` in 64: memory read data.
- `busy` out 1: `state != IDLE` or FIFO not empty.

## Operation
- Address split:
  - `addr[2:0]` ignored for lookup.
  - index = `addr[IDX+2:3]`.
  - tag = `addr[63:IDX+3]`.
- Line store: per line one valid bit, one tag and 64 data bits.
  - Valid bits are flops cleared by reset.
  - Tag and data are not reset.
- Request FIFO:
  - Push on `miss_valid && miss_ready`.
  - Pop only in IDLE when not empty.
  - Strict order; no merging of duplicate addresses. Duplicates are served twice, and the second is an L2 hit.
- FSM states: IDLE, LOOKUP, MEM_WAIT, RESP.
  - IDLE: if FIFO not empty, pop head into `cur_addr` → LOOKUP. Otherwise stay.
  - LOOKUP: read line at index of `cur_addr`.
    - Hit (valid and tag equal): register the line data into `fill_data` → RESP.
    - Miss → MEM_WAIT.
  - MEM_WAIT: `mem_req`=1 and `mem_addr`=`cur_addr`, both stable until the edge that samples `mem_ack`=1. On that edge:
    - write line: valid=1, tag, data=`mem_data`. This replaces any prior occupant; there is no write-back, because the L2 is clean.
    - `fill_data`←`mem_data`.
    - → RESP.
  - RESP: `fill_valid`=1 for exactly this one cycle, `fill_addr`=`cur_addr`, → IDLE.
- `fill_addr` and `fill_data` hold their last values outside RESP. `mem_addr` holds its last value outside MEM_WAIT.
- `mem_ack` outside MEM_WAIT is ignored.
- Simultaneous push and pop in IDLE are both legal in one cycle.
  - When the FIFO is full, `miss_ready`=0, even if a pop occurs that cycle.
- No store path: L1 stores are not propagated. Stale-data coherence is outside this block's scope.

## Timing
- Reset values:
  - state IDLE, FIFO empty, all valid bits 0.
  - `miss_ready`=1, `fill_valid`=0, `fill_addr`=0, `fill_data`=0, `mem_req`=0, `mem_addr`=0, `busy`=0.
- Reset mid-operation:
  - Immediate return to the reset values.
  - Queued and in-flight requests are discarded.
  - `mem_req` drops asynchronously, and a later `mem_ack` is ignored.
- Hit latency, counting the accepting edge as edge 0 with the block idle: IDLE pops at edge 1, LOOKUP resolves at edge 2, `fill_valid` is high between edges 2 and 3.
- Miss latency: `mem_req` is high from edge 2. If `mem_ack` is sampled at edge k ≥ 3, `fill_valid` is high between edges k and k+1.
- Back-to-back hits: one response every 3 cycles; the sustained throughput is 1/3.
- `fill_valid` is never high in two consecutive cycles.

## Test plan
- Cold miss: reset, push 0x1000.
  - Required: `mem_req` with `mem_addr`=0x1000.
  - Ack 2 cycles later with `mem_data`=0xDEADBEEF_00000001.
  - Required: one `fill_valid` pulse, `fill_addr`=0x1000, data equal to `mem_data`.
- Hit after fill: push 0x1000 again.
  - Required: no `mem_req`; `fill_valid` between edges 2 and 3 with the same data.
- Conflict eviction with `LINES`=256: push 0x1000, then 0x1800 (same index, different tag), then 0x1000.
  - Required: three `mem_req`, in order 0x1000, 0x1800, 0x1000.
- Queue full: stall `mem_ack` and push 5 distinct addresses.
  - Required: `miss_ready`=0 once 4 are queued while the first waits in MEM_WAIT.
  - Release acks.
  - Required: fills return in push order, each `fill_addr` exact.
- Reset mid-miss: assert `reset` during MEM_WAIT.
  - Required: `mem_req` falls immediately and `busy`=0.
  - Required: a late `mem_ack` produces no `fill_valid`.
  - Required: a subsequent push of the same address misses again, because valid bits were cleared.
- Low-bit passthrough: push 0x1003 after 0x1000 is resident.
  - Required: a hit, `fill_addr`=0x1003, data of line 0x1000.
